fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage directly upstream of the instruction queue.
//  Holds the PC and issues one instruction read at a time to instruction memory.
//  Pushes each returned {pc, instr} pair into the queue through its w_en/w_data/full_sig write port.
//  Handles backend redirects, discarding any stale in-flight or buffered instruction.
// PARAMETERS
//  RESET_PC  32'h1eceb000  PC fetched first after reset
//  Q_WIDTH   64            queue entry width; fixed layout {pc[31:0], instr[31:0]}
// PORTS
//  clk          in   1        clock, all state on posedge
//  rst          in   1        reset, ASYNCHRONOUS, ACTIVE-LOW (0 = in reset)
//  imem_addr    out  32       read address, always equals pc
//  imem_rmask   out  4        4'hf for the single launch cycle of a request, else 4'h0
//  imem_rdata   in   32       instruction data, valid when imem_resp=1
//  imem_resp    in   1        one-cycle response strobe, arrives >=1 cycle after launch
//  redirect_en  in   1        one-cycle redirect strobe from the backend
//  redirect_pc  in   32       redirect target; bits [1:0] forced to 0
//  full_sig     in   1        queue full
//  w_en         out  1        queue push strobe
//  w_data       out  Q_WIDTH  {pc, instr} entry being pushed
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, pc=RESET_PC, hold buffer=0, drop=0.
//   Outputs are immediate: imem_rmask=0, w_en=0, w_data=0, imem_addr=RESET_PC.
//  Limit: at most one outstanding memory request.
//  FSM states IDLE, WAIT, HOLD:
//   IDLE: if !full_sig && !redirect_en, then imem_rmask=4'hf (combinational) and next state WAIT.
//    Otherwise no request is launched and the state stays IDLE.
//    An imem_resp seen in IDLE is ignored.
//   WAIT: imem_rmask=0. On imem_resp:
//    drop=0 and !redirect_en: buf<={pc,imem_rdata}, next state HOLD.
//    drop=1 or redirect_en: discard the data, clear drop, next state IDLE.
//   HOLD: w_en = !full_sig && !redirect_en (combinational); w_data=buf.
//    On push: pc<=pc+4 (mod 2^32, wraps), next state IDLE.
//    While full_sig=1: stay in HOLD, buf unchanged, w_en=0.
//  w_data: 0 whenever w_en=0.
//  Redirect (any state; priority over everything except reset): pc<={redirect_pc[31:2],2'b00}.
//   IDLE: no launch that cycle; the next launch uses the new pc.
//   WAIT without resp in the same cycle: set drop=1, stay in WAIT until the stale resp, then IDLE.
//   WAIT with resp in the same cycle: data discarded, next state IDLE.
//   HOLD: buf discarded, w_en=0, next state IDLE.
//   Redirect arriving while drop=1: pc is updated, drop stays 1.
//  Latency (no stalls): launch at T, resp at T+k, push at T+k+1, next launch at T+k+2.
//  pc advances only on a successful push or on a redirect. No instruction is pushed twice or skipped.
//  After a reset mid-request, a late imem_resp lands in IDLE and is ignored.
// TESTING
//  1. Reset release, 1-cycle memory, rdata=32'h00000013 -> launch at addr 1eceb000;
//     push w_data={32'h1eceb000,32'h13}; next launch at 1eceb004.
//  2. full_sig=1 held 5 cycles in IDLE -> imem_rmask=0 throughout;
//     full_sig drops -> rmask=4'hf in that same cycle.
//  3. full_sig rises while in HOLD for 3 cycles -> w_en=0 and buf held;
//     after the drop, one push with the unchanged value; pc +4 exactly once.
//  4. redirect_en with redirect_pc=32'h1eceb103 during WAIT, resp 3 cycles later ->
//     no w_en; next launch addr=32'h1eceb100.
//  5. redirect_en in the same cycle as imem_resp, and separately during HOLD ->
//     no push, next launch at the redirect target.
//  6. rst=0 asserted mid-WAIT -> outputs zero immediately; late resp ignored;
//     after release, the first launch is at RESET_PC.
//  7. Scoreboard: 32 sequential fetches with random memory latency 1-4 and random full_sig ->
//     pushed pcs strictly sequential from RESET_PC, data matches the memory model.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage feeding the instruction queue.
//   Holds the PC, keeps at most one instruction-memory read outstanding and
//   pushes each returned {pc, instr} pair into the queue write port. Backend
//   redirects retarget the PC and discard any stale in-flight or buffered
//   instruction.
// Ports:
//   clk          clock, all state on posedge
//   rst          asynchronous active-low reset (0 = in reset)
//   imem_addr    read address, always the current pc
//   imem_rmask   4'hf during the single launch cycle of a request
//   imem_rdata   instruction data, valid with imem_resp
//   imem_resp    one-cycle response strobe
//   redirect_en  one-cycle redirect strobe from the backend
//   redirect_pc  redirect target (low two bits ignored)
//   full_sig     queue full
//   w_en         queue push strobe
//   w_data       {pc, instr} entry being pushed, 0 when w_en=0
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int unsigned Q_WIDTH  = 64
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        imem_addr,
  output logic [3:0]         imem_rmask,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_resp,
  input  logic               redirect_en,
  input  logic [31:0]        redirect_pc,
  input  logic               full_sig,
  output logic               w_en,
  output logic [Q_WIDTH-1:0] w_data
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PC_STEP  = 4;
  localparam int unsigned ENTRY_W  = 2 * XLEN;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  entry_t          hold_q, hold_n;
  logic            drop, drop_n;
  logic            launch;
  logic            push;

  // State, pc, hold buffer and stale-response flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      hold_q <= '0;
      drop   <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      hold_q <= hold_n;
      drop   <= drop_n;
    end
  end

  // Next-state, launch and push decode.
  // launch/push are gated with rst so the strobes are quiet while reset is held.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    hold_n  = hold_q;
    drop_n  = drop;
    launch  = 1'b0;
    push    = 1'b0;

    case (state)
      IDLE: begin
        if (rst && !full_sig && !redirect_en) begin
          launch  = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp) begin
          if (!drop && !redirect_en) begin
            hold_n  = '{pc: pc, instr: imem_rdata};
            state_n = HOLD;
          end else begin
            // Stale or redirected response: throw it away.
            drop_n  = 1'b0;
            state_n = IDLE;
          end
        end else if (redirect_en) begin
          // Request still in flight; its response must be swallowed.
          drop_n = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_en) begin
          hold_n  = '0;
          state_n = IDLE;
        end else if (rst && !full_sig) begin
          push    = 1'b1;
          pc_n    = pc + XLEN'(PC_STEP);
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (redirect_en) begin
      pc_n = {redirect_pc[XLEN-1:2], 2'b00};
    end
  end

  assign imem_addr  = pc;
  assign imem_rmask = launch ? 4'hf : 4'h0;
  assign w_en       = push;
  assign w_data     = push ? Q_WIDTH'(ENTRY_W'(hold_q)) : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of the fetch stage against a small
// instruction-memory model, plus a scoreboarded run with random memory
// latency and random queue-full back-pressure.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h1eceb000;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        full_sig;
  logic        w_en;
  logic [63:0] w_data;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.RESET_PC(RESET_PC), .Q_WIDTH(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .full_sig    (full_sig),
    .w_en        (w_en),
    .w_data      (w_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h1eceb000) ? 32'h00000013 : (a ^ 32'h5a5ac3c3);
  endfunction

  // Memory model: capture a launch on negedge, answer lat cycles later.
  logic        pend;
  int          cnt;
  int          lat;
  logic [31:0] addr_l;

  initial begin
    pend   = 1'b0;
    cnt    = 0;
    addr_l = '0;
    forever begin
      @(negedge clk);
      if (rst && imem_rmask == 4'hf) begin
        pend   = 1'b1;
        cnt    = lat;
        addr_l = imem_addr;
      end
    end
  end

  initial begin
    imem_resp  = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_resp  = 1'b0;
      imem_rdata = '0;
      if (pend) begin
        if (cnt <= 1) begin
          imem_resp  = 1'b1;
          imem_rdata = mem_word(addr_l);
          pend       = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Push monitor and scoreboard.
  int          push_cnt = 0;
  logic        sb_on    = 1'b0;
  logic [31:0] exp_pc   = RESET_PC;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst && w_en) begin
        push_cnt++;
        if (sb_on) begin
          check_eq("t7_push", w_data, {exp_pc, mem_word(exp_pc)});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic run_until_push(input int max, output logic [63:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < max && !ok; i++) begin
      cyc();
      smp();
      if (w_en) begin
        ok = 1'b1;
        d  = w_data;
      end
    end
  endtask

  logic [63:0] d;
  bit          ok;
  int          base;

  initial begin
    rst         = 1'b1;
    full_sig    = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    lat         = 1;
    #1 rst = 1'b0;

    // Reset state
    smp();
    check_eq("rst_rmask", 64'(imem_rmask), 64'h0);
    check_eq("rst_wen", 64'(w_en), 64'h0);
    check_eq("rst_wdata", w_data, 64'h0);
    check_eq("rst_addr", 64'(imem_addr), 64'(RESET_PC));

    // 1: first fetch with 1-cycle memory
    cyc(); rst = 1'b1; smp();
    check_eq("t1_launch_rmask", 64'(imem_rmask), 64'hf);
    check_eq("t1_launch_addr", 64'(imem_addr), 64'h1eceb000);
    cyc(); smp();
    check_eq("t1_wait_rmask", 64'(imem_rmask), 64'h0);
    check_eq("t1_wait_wen", 64'(w_en), 64'h0);
    cyc(); smp();
    check_eq("t1_push_wen", 64'(w_en), 64'h1);
    check_eq("t1_push_data", w_data, {32'h1eceb000, 32'h00000013});
    cyc(); smp();
    check_eq("t1_next_rmask", 64'(imem_rmask), 64'hf);
    check_eq("t1_next_addr", 64'(imem_addr), 64'h1eceb004);
    run_until_push(10, d, ok);
    check_eq("t1_push2_seen", 64'(ok), 64'h1);
    check_eq("t1_push2_data", d, {32'h1eceb004, mem_word(32'h1eceb004)});

    // 2: full in IDLE blocks launch; release launches same cycle
    lat = 2;
    for (int i = 0; i < 5; i++) begin
      cyc(); full_sig = 1'b1; smp();
      check_eq("t2_full_rmask", 64'(imem_rmask), 64'h0);
    end
    cyc(); full_sig = 1'b0; smp();
    check_eq("t2_rel_rmask", 64'(imem_rmask), 64'hf);
    check_eq("t2_rel_addr", 64'(imem_addr), 64'h1eceb008);

    // 3: full while in HOLD
    cyc(); smp();
    cyc(); smp();
    for (int i = 0; i < 3; i++) begin
      cyc(); full_sig = 1'b1; smp();
      check_eq("t3_hold_wen", 64'(w_en), 64'h0);
      check_eq("t3_hold_wdata", w_data, 64'h0);
      check_eq("t3_hold_addr", 64'(imem_addr), 64'h1eceb008);
    end
    lat = 4;
    cyc(); full_sig = 1'b0; smp();
    check_eq("t3_push_wen", 64'(w_en), 64'h1);
    check_eq("t3_push_data", w_data, {32'h1eceb008, mem_word(32'h1eceb008)});
    cyc(); smp();
    check_eq("t3_next_rmask", 64'(imem_rmask), 64'hf);
    check_eq("t3_next_addr", 64'(imem_addr), 64'h1eceb00c);

    // 4: redirect during WAIT, stale response three cycles later
    base = push_cnt;
    cyc(); redirect_en = 1'b1; redirect_pc = 32'h1eceb103; smp();
    cyc(); redirect_en = 1'b0; smp();
    check_eq("t4_addr", 64'(imem_addr), 64'h1eceb100);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        cyc(); smp();
      end
      check_eq("t4_wait_rmask", 64'(imem_rmask), 64'h0);
      check_eq("t4_wait_wen", 64'(w_en), 64'h0);
    end
    lat = 1;
    cyc(); smp();
    check_eq("t4_next_rmask", 64'(imem_rmask), 64'hf);
    check_eq("t4_next_addr", 64'(imem_addr), 64'h1eceb100);

    // 5a: redirect in the same cycle as the response
    cyc(); redirect_en = 1'b1; redirect_pc = 32'h1eceb200; smp();
    check_eq("t5a_wen", 64'(w_en), 64'h0);
    cyc(); redirect_en = 1'b0; smp();
    check_eq("t5a_next_rmask", 64'(imem_rmask), 64'hf);
    check_eq("t5a_next_addr", 64'(imem_addr), 64'h1eceb200);

    // 5b: redirect during HOLD
    cyc(); smp();
    cyc(); redirect_en = 1'b1; redirect_pc = 32'h1eceb304; smp();
    check_eq("t5b_wen", 64'(w_en), 64'h0);
    check_eq("t5b_wdata", w_data, 64'h0);
    lat = 3;
    cyc(); redirect_en = 1'b0; smp();
    check_eq("t5b_next_rmask", 64'(imem_rmask), 64'hf);
    check_eq("t5b_next_addr", 64'(imem_addr), 64'h1eceb304);
    check_eq("t45_no_push", 64'(push_cnt - base), 64'h0);

    // 6: reset mid-WAIT, late response ignored
    cyc(); smp();
    cyc(); rst = 1'b0; smp();
    check_eq("t6_rst_rmask", 64'(imem_rmask), 64'h0);
    check_eq("t6_rst_wen", 64'(w_en), 64'h0);
    check_eq("t6_rst_wdata", w_data, 64'h0);
    check_eq("t6_rst_addr", 64'(imem_addr), 64'(RESET_PC));
    cyc(); rst = 1'b1; full_sig = 1'b1; lat = 1; smp();
    check_eq("t6_late_wen", 64'(w_en), 64'h0);
    cyc(); full_sig = 1'b0; smp();
    check_eq("t6_launch_rmask", 64'(imem_rmask), 64'hf);
    check_eq("t6_launch_addr", 64'(imem_addr), 64'(RESET_PC));
    run_until_push(10, d, ok);
    check_eq("t6_push_seen", 64'(ok), 64'h1);
    check_eq("t6_push_data", d, {RESET_PC, 32'h00000013});

    // 7: 32 fetches, random latency and back-pressure
    cyc(); rst = 1'b0; smp();
    cyc(); smp();
    cyc(); rst = 1'b1; smp();
    exp_pc = RESET_PC;
    sb_on  = 1'b1;
    base   = push_cnt;
    for (int i = 0; i < 3000 && (push_cnt - base) < 32; i++) begin
      cyc();
      full_sig = ($urandom_range(0, 3) == 0);
      lat      = int'($urandom_range(1, 4));
    end
    check_eq("t7_count", 64'(push_cnt - base), 64'd32);
    smp();
    sb_on    = 1'b0;
    full_sig = 1'b0;
    lat      = 1;

    // 8: pc wraps past 2^32
    cyc(); redirect_en = 1'b1; redirect_pc = 32'hfffffffe; smp();
    cyc(); redirect_en = 1'b0; smp();
    check_eq("t8_addr", 64'(imem_addr), 64'hfffffffc);
    run_until_push(40, d, ok);
    check_eq("t8_push_seen", 64'(ok), 64'h1);
    check_eq("t8_push_data", d, {32'hfffffffc, mem_word(32'hfffffffc)});
    cyc(); smp();
    check_eq("t8_wrap_rmask", 64'(imem_rmask), 64'hf);
    check_eq("t8_wrap_addr", 64'(imem_addr), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
